// File: rtl/usb_packet_decoder.sv
// Decodes the SIE receive byte stream: validates PIDs, classifies token, SOF, data and
// handshake packets, and forwards data payloads with the trailing CRC16 held back.
module usb_packet_decoder #(
  parameter int unsigned MAX_PAYLOAD = 1023,
  parameter int unsigned LEN_WIDTH   = 11
) (
  input  logic                 clk48,
  input  logic                 RST_N,
  input  logic [6:0]           deviceAddr,
  input  logic [7:0]           rxData,
  input  logic                 rxDataValid,
  input  logic                 rxIsLastByte,
  input  logic                 keepPacket,
  output logic                 rxAcceptNewData,
  output logic                 tokenValid,
  output logic [3:0]           tokenPid,
  output logic [3:0]           tokenEndp,
  output logic                 sofValid,
  output logic [10:0]          frameNum,
  output logic                 handshakeValid,
  output logic [3:0]           handshakePid,
  output logic [3:0]           dataPid,
  output logic [7:0]           payloadData,
  output logic                 payloadValid,
  output logic                 payloadLast,
  input  logic                 payloadReady,
  output logic [LEN_WIDTH-1:0] payloadLen,
  output logic                 pktDone,
  output logic                 pktOk
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TOK1 = 3'd1,
    S_TOK2 = 3'd2,
    S_DATA = 3'd3,
    S_SKIP = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           pid_q, pid_d;
  logic                 is_sof_q, is_sof_d;
  logic [7:0]           byte1_q, byte1_d;
  logic [7:0]           hold0_q, hold0_d;
  logic [7:0]           hold1_q, hold1_d;
  logic [1:0]           hcnt_q, hcnt_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic                 token_valid_q, token_valid_d;
  logic [3:0]           token_pid_q, token_pid_d;
  logic [3:0]           token_endp_q, token_endp_d;
  logic                 sof_valid_q, sof_valid_d;
  logic [10:0]          frame_num_q, frame_num_d;
  logic                 hs_valid_q, hs_valid_d;
  logic [3:0]           hs_pid_q, hs_pid_d;
  logic [3:0]           data_pid_q, data_pid_d;
  logic [7:0]           pay_data_q, pay_data_d;
  logic                 pay_valid_q, pay_valid_d;
  logic                 pay_last_q, pay_last_d;
  logic [LEN_WIDTH-1:0] pay_len_q, pay_len_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 pkt_ok_q, pkt_ok_d;

  logic accept_c;
  logic xfer_c;
  logic pid_ok_c;
  logic fin_c;
  logic fin_ok_c;

  // Stall the receive side only when a full holdback must shift into a busy payload register
  assign accept_c = !((state_q == S_DATA) && (hcnt_q == 2'd2) && pay_valid_q && !payloadReady);
  assign xfer_c   = rxDataValid && accept_c;
  assign pid_ok_c = (rxData[7:4] == ~rxData[3:0]);

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    is_sof_d      = is_sof_q;
    byte1_d       = byte1_q;
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    hcnt_d        = hcnt_q;
    cnt_d         = cnt_q;
    token_valid_d = 1'b0;
    token_pid_d   = token_pid_q;
    token_endp_d  = token_endp_q;
    sof_valid_d   = 1'b0;
    frame_num_d   = frame_num_q;
    hs_valid_d    = 1'b0;
    hs_pid_d      = hs_pid_q;
    data_pid_d    = data_pid_q;
    pay_data_d    = pay_data_q;
    pay_valid_d   = pay_valid_q;
    pay_last_d    = pay_last_q;
    pay_len_d     = pay_len_q;
    pkt_done_d    = 1'b0;
    pkt_ok_d      = pkt_ok_q;
    fin_c         = 1'b0;
    fin_ok_c      = 1'b0;

    if (pay_valid_q && payloadReady) begin
      pay_valid_d = 1'b0;
    end

    if (xfer_c) begin
      unique case (state_q)
        S_IDLE: begin
          pid_d = rxData[3:0];
          if (!pid_ok_c) begin
            if (rxIsLastByte) fin_c = 1'b1;
            else              state_d = S_SKIP;
          end else begin
            unique case (rxData[3:0])
              PID_OUT, PID_IN, PID_SETUP, PID_SOF: begin
                is_sof_d = (rxData[3:0] == PID_SOF);
                if (rxIsLastByte) fin_c = 1'b1;
                else              state_d = S_TOK1;
              end
              PID_DATA0, PID_DATA1: begin
                data_pid_d = rxData[3:0];
                cnt_d      = '0;
                hcnt_d     = 2'd0;
                if (rxIsLastByte) fin_c = 1'b1;
                else              state_d = S_DATA;
              end
              PID_ACK, PID_NAK, PID_STALL: begin
                if (rxIsLastByte) begin
                  fin_c      = 1'b1;
                  fin_ok_c   = keepPacket;
                  hs_valid_d = keepPacket;
                  if (keepPacket) hs_pid_d = rxData[3:0];
                end else begin
                  state_d = S_SKIP;
                end
              end
              default: begin
                if (rxIsLastByte) fin_c = 1'b1;
                else              state_d = S_SKIP;
              end
            endcase
          end
        end

        S_TOK1: begin
          byte1_d = rxData;
          if (rxIsLastByte) fin_c = 1'b1;
          else              state_d = S_TOK2;
        end

        S_TOK2: begin
          if (!rxIsLastByte) begin
            state_d = S_SKIP;
          end else begin
            fin_c    = 1'b1;
            fin_ok_c = keepPacket;
            if (keepPacket && is_sof_q) begin
              sof_valid_d = 1'b1;
              frame_num_d = {rxData[2:0], byte1_q};
            end else if (keepPacket && (byte1_q[6:0] == deviceAddr)) begin
              token_valid_d = 1'b1;
              token_pid_d   = pid_q;
              token_endp_d  = {rxData[2:0], byte1_q[7]};
            end
          end
        end

        S_DATA: begin
          if (hcnt_q == 2'd2) begin
            if (cnt_q == LEN_WIDTH'(MAX_PAYLOAD)) begin
              if (rxIsLastByte) fin_c = 1'b1;
              else              state_d = S_SKIP;
            end else begin
              // Oldest held byte is now known not to be CRC, so it becomes payload
              pay_data_d  = hold0_q;
              pay_valid_d = 1'b1;
              pay_last_d  = rxIsLastByte;
              cnt_d       = cnt_q + LEN_WIDTH'(1);
              hold0_d     = hold1_q;
              hold1_d     = rxData;
              if (rxIsLastByte) begin
                fin_c     = 1'b1;
                fin_ok_c  = keepPacket;
                pay_len_d = cnt_q + LEN_WIDTH'(1);
              end
            end
          end else if (rxIsLastByte) begin
            fin_c     = 1'b1;
            fin_ok_c  = keepPacket && (hcnt_q == 2'd1);
            pay_len_d = cnt_q;
          end else begin
            if (hcnt_q == 2'd0) hold0_d = rxData;
            else                hold1_d = rxData;
            hcnt_d = hcnt_q + 2'd1;
          end
        end

        S_SKIP: begin
          if (rxIsLastByte) fin_c = 1'b1;
        end

        default: state_d = S_IDLE;
      endcase
    end

    if (fin_c) begin
      pkt_done_d = 1'b1;
      pkt_ok_d   = fin_ok_c;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clk48 or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      pid_q         <= '0;
      is_sof_q      <= 1'b0;
      byte1_q       <= '0;
      hold0_q       <= '0;
      hold1_q       <= '0;
      hcnt_q        <= '0;
      cnt_q         <= '0;
      token_valid_q <= 1'b0;
      token_pid_q   <= '0;
      token_endp_q  <= '0;
      sof_valid_q   <= 1'b0;
      frame_num_q   <= '0;
      hs_valid_q    <= 1'b0;
      hs_pid_q      <= '0;
      data_pid_q    <= '0;
      pay_data_q    <= '0;
      pay_valid_q   <= 1'b0;
      pay_last_q    <= 1'b0;
      pay_len_q     <= '0;
      pkt_done_q    <= 1'b0;
      pkt_ok_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      is_sof_q      <= is_sof_d;
      byte1_q       <= byte1_d;
      hold0_q       <= hold0_d;
      hold1_q       <= hold1_d;
      hcnt_q        <= hcnt_d;
      cnt_q         <= cnt_d;
      token_valid_q <= token_valid_d;
      token_pid_q   <= token_pid_d;
      token_endp_q  <= token_endp_d;
      sof_valid_q   <= sof_valid_d;
      frame_num_q   <= frame_num_d;
      hs_valid_q    <= hs_valid_d;
      hs_pid_q      <= hs_pid_d;
      data_pid_q    <= data_pid_d;
      pay_data_q    <= pay_data_d;
      pay_valid_q   <= pay_valid_d;
      pay_last_q    <= pay_last_d;
      pay_len_q     <= pay_len_d;
      pkt_done_q    <= pkt_done_d;
      pkt_ok_q      <= pkt_ok_d;
    end
  end

  assign rxAcceptNewData = accept_c;
  assign tokenValid      = token_valid_q;
  assign tokenPid        = token_pid_q;
  assign tokenEndp       = token_endp_q;
  assign sofValid        = sof_valid_q;
  assign frameNum        = frame_num_q;
  assign handshakeValid  = hs_valid_q;
  assign handshakePid    = hs_pid_q;
  assign dataPid         = data_pid_q;
  assign payloadData     = pay_data_q;
  assign payloadValid    = pay_valid_q;
  assign payloadLast     = pay_last_q;
  assign payloadLen      = pay_len_q;
  assign pktDone         = pkt_done_q;
  assign pktOk           = pkt_ok_q;

endmodule
